// File: rtl/map_port_arbiter.sv
// map_port_arbiter: round-robin read-modify-write arbiter for map RAM port B (one tile nibble per op).
// Define MAP_ARB_BOUNDS_EN to reject out-of-range row/col requests with an err pulse instead of touching RAM.
module map_port_arbiter #(
  parameter int RD_LAT = 2,
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int TILE_W = 4
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [1:0]                 req,
  input  logic [$clog2(ROWS)-1:0]    req0_row,
  input  logic [$clog2(ROWS)-1:0]    req1_row,
  input  logic [$clog2(COLS)-1:0]    req0_col,
  input  logic [$clog2(COLS)-1:0]    req1_col,
  input  logic [TILE_W-1:0]          req0_tile,
  input  logic [TILE_W-1:0]          req1_tile,
  output logic [1:0]                 gnt,
  output logic [1:0]                 done,
  output logic [1:0]                 err,
  output logic [TILE_W-1:0]          old_tile,
  output logic                       busy,
  output logic [$clog2(ROWS)-1:0]    wraddr,
  output logic [COLS*TILE_W-1:0]     wrdata,
  output logic                       wren,
  input  logic [COLS*TILE_W-1:0]     redata
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = COLS * TILE_W;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t            state_q, state_d;
  logic              win_q, win_d, last_q, last_d, oob_q, oob_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [RW-1:0]     wraddr_q, wraddr_d;
  logic [CW-1:0]     col_q, col_d;
  logic [TILE_W-1:0] tile_q, tile_d, old_q, old_d, cur_nib;
  logic [DW-1:0]     data_q, data_d, spliced;
  logic [1:0]        onehot;
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      oob_q    <= 1'b0;
      cnt_q    <= '0;
      wraddr_q <= '0;
      col_q    <= '0;
      tile_q   <= '0;
      old_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      oob_q    <= oob_d;
      cnt_q    <= cnt_d;
      wraddr_q <= wraddr_d;
      col_q    <= col_d;
      tile_q   <= tile_d;
      old_q    <= old_d;
      data_q   <= data_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    last_d   = last_q;
    oob_d    = oob_q;
    cnt_d    = '0;
    wraddr_d = wraddr_q;
    col_d    = col_q;
    tile_d   = tile_q;
    old_d    = old_q;
    data_d   = data_q;
    case (state_q)
      IDLE: if (|req) begin
        win_d    = &req ? ~last_q : req[1];
        wraddr_d = win_d ? req1_row : req0_row;
        col_d    = win_d ? req1_col : req0_col;
        tile_d   = win_d ? req1_tile : req0_tile;
`ifdef MAP_ARB_BOUNDS_EN
        oob_d    = (wraddr_d >= RW'(ROWS)) || (col_d >= CW'(COLS));
`else
        oob_d    = 1'b0;
`endif
        old_d    = '0;
        state_d  = READ;
      end
      READ: begin
        cnt_d = cnt_q + 3'd1;
        if (oob_q) state_d = DONE;
        else if (cnt_q == 3'(RD_LAT - 1)) begin
          data_d  = redata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        old_d   = cur_nib;
        state_d = DONE;
      end
      default: begin
        last_d  = win_q;
        state_d = IDLE;
      end
    endcase
  end
  // column 0 is the most significant nibble; out-of-range columns leave the row intact
  always_comb begin
    spliced = data_q;
    cur_nib = '0;
    for (int c = 0; c < COLS; c++)
      if (col_q == CW'(c)) begin
        cur_nib = data_q[(COLS-1-c)*TILE_W +: TILE_W];
        spliced[(COLS-1-c)*TILE_W +: TILE_W] = tile_q;
      end
  end
  always_comb begin
    onehot   = win_q ? 2'b10 : 2'b01;
    busy     = state_q != IDLE;
    wren     = state_q == WRITE;
    wrdata   = wren ? spliced : '0;
    gnt      = (state_q == READ && cnt_q == '0) ? onehot : 2'b00;
    done     = (state_q == DONE) ? onehot : 2'b00;
    err      = (state_q == DONE && oob_q) ? onehot : 2'b00;
    old_tile = old_q;
    wraddr   = wraddr_q;
  end
endmodule

// File: tb/tb_map_port_arbiter.sv
// tb_map_port_arbiter: randomized bench with a row-array RAM and a nibble-level reference map.
module tb_map_port_arbiter;
  localparam int RD_LAT = 2;
  logic         CLOCK_50 = 1'b0, reset = 1'b1;
  logic [1:0]   req = '0;
  logic [4:0]   req0_row = '0, req1_row = '0;
  logic [5:0]   req0_col = '0, req1_col = '0;
  logic [3:0]   req0_tile = '0, req1_tile = '0;
  logic [1:0]   gnt, done, err, gnt4, done4, err4;
  logic [3:0]   old_tile, old_tile4;
  logic         busy, wren, busy4, wren4;
  logic [4:0]   wraddr, wraddr4;
  logic [159:0] wrdata, wrdata4, redata = '0;
  logic [159:0] redata4 = {160{1'b1}};
  logic [159:0] ram [32];
  logic [159:0] ref_mem [32];
  logic         ld = 1'b0;
  logic [4:0]   ld_a = '0, last_a = '0;
  logic [159:0] ld_d = '0;
  int           stab = 0, total = 0, bad = 0, last = 1;

  map_port_arbiter #(.RD_LAT(RD_LAT)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .req(req),
    .req0_row(req0_row), .req1_row(req1_row), .req0_col(req0_col), .req1_col(req1_col),
    .req0_tile(req0_tile), .req1_tile(req1_tile), .gnt(gnt), .done(done), .err(err),
    .old_tile(old_tile), .busy(busy), .wraddr(wraddr), .wrdata(wrdata), .wren(wren), .redata(redata));

  map_port_arbiter #(.RD_LAT(4)) dut4 (
    .CLOCK_50(CLOCK_50), .reset(reset), .req(req),
    .req0_row(req0_row), .req1_row(req1_row), .req0_col(req0_col), .req1_col(req1_col),
    .req0_tile(req0_tile), .req1_tile(req1_tile), .gnt(gnt4), .done(done4), .err(err4),
    .old_tile(old_tile4), .busy(busy4), .wraddr(wraddr4), .wrdata(wrdata4), .wren(wren4), .redata(redata4));

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50)
    if (ld) ram[ld_a] <= ld_d;
    else if (wren) ram[wraddr] <= wrdata;

  // read data is garbage until the address has been stable for the read latency
  always @(negedge CLOCK_50) begin
    stab   <= (wraddr == last_a) ? stab + 1 : 0;
    last_a <= wraddr;
    redata <= (((wraddr == last_a) ? stab + 1 : 0) >= RD_LAT - 1) ? ram[wraddr]
              : {$urandom, $urandom, $urandom, $urandom, $urandom};
  end

  task automatic do_reset;
    reset = 1'b1;
    req   = '0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    last  = 1;
  endtask

  task automatic init_mem;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLOCK_50);
      ld   = 1'b1;
      ld_a = 5'(i);
      ld_d = {$urandom, $urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = ld_d;
    end
    @(negedge CLOCK_50);
    ld = 1'b0;
  endtask

  task automatic load_row(input int a, input logic [159:0] d);
    @(negedge CLOCK_50);
    ld = 1'b1; ld_a = 5'(a); ld_d = d; ref_mem[a] = d;
    @(negedge CLOCK_50);
    ld = 1'b0;
  endtask

  task automatic new_ops(input int w);
    logic [4:0] r;
    logic [5:0] c;
    r = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(30, 31)) : 5'($urandom_range(0, 29));
    c = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 39));
    if (w == 0) begin req0_row = r; req0_col = c; req0_tile = 4'($urandom); end
    else        begin req1_row = r; req1_col = c; req1_tile = 4'($urandom); end
  endtask

  // one full transaction: winner predicted from req and the last-served pointer
  task automatic op(input bit keep, output int waited);
    int w, ci;
    logic [4:0] r;
    logic [5:0] c;
    logic [3:0] t, exp_old;
    logic [159:0] exp_row;
    logic [1:0] oh;
    bit skip;
    w  = (req == 2'b11) ? 1 - last : (req[1] ? 1 : 0);
    oh = 2'(1 << w);
    r  = w ? req1_row : req0_row;
    c  = w ? req1_col : req0_col;
    t  = w ? req1_tile : req0_tile;
    waited = 0;
    while (gnt === 2'b00 && waited < 20) begin
      @(negedge CLOCK_50);
      waited++;
    end
    total++;
    if (gnt !== oh) begin
      bad++;
      $display("FAIL gnt: got %b want %b", gnt, oh);
      return;
    end
    if (!keep) req[w] = 1'b0;
    new_ops(w);
    ci   = int'(c);
    skip = 1'b0;
`ifdef MAP_ARB_BOUNDS_EN
    skip = (r >= 5'd30) || (ci >= 40);
`endif
    exp_row = ref_mem[r];
    exp_old = '0;
    if (ci < 40) begin
      exp_old = exp_row[(39-ci)*4 +: 4];
      exp_row[(39-ci)*4 +: 4] = t;
    end
    if (skip) begin
      @(negedge CLOCK_50);
      total++;
      if ({done, err, wren, old_tile} !== {oh, oh, 1'b0, 4'h0}) begin
        bad++;
        $display("FAIL oob_done: got done=%b err=%b wren=%b old=%h want %b %b 0 0", done, err, wren, old_tile, oh, oh);
      end
    end else begin
      for (int k = 1; k <= RD_LAT + 1; k++) begin
        @(negedge CLOCK_50);
        total++;
        if (wren !== (k == RD_LAT) || done !== ((k == RD_LAT + 1) ? oh : 2'b00) || err !== 2'b00 || busy !== 1'b1) begin
          bad++;
          $display("FAIL seq k=%0d: got wren=%b done=%b err=%b busy=%b want wren=%b done=%b", k, wren, done, err, busy,
                   k == RD_LAT, (k == RD_LAT + 1) ? oh : 2'b00);
        end
        if (k == RD_LAT) begin
          total++;
          if (wrdata !== exp_row || wraddr !== r) begin
            bad++;
            $display("FAIL wrdata: got %h @%0d want %h @%0d", wrdata, wraddr, exp_row, r);
          end
        end
      end
      total++;
      if (old_tile !== exp_old) begin
        bad++;
        $display("FAIL old_tile: got %h want %h", old_tile, exp_old);
      end
      ref_mem[r] = exp_row;
    end
    last = w;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge CLOCK_50);
    total++;
    if ({gnt, done, err, old_tile, busy, wraddr, wren} !== 17'd0 || wrdata !== '0) begin
      bad++;
      $display("FAIL reset_state: got gnt=%b done=%b err=%b old=%h busy=%b addr=%h wren=%b want all 0",
               gnt, done, err, old_tile, busy, wraddr, wren);
    end
    reset = 1'b0;
    last  = 1;
    @(negedge CLOCK_50);
    total++;
    if ({gnt, busy, wren} !== 4'd0) begin
      bad++;
      $display("FAIL idle_after_reset: got gnt=%b busy=%b wren=%b want 0", gnt, busy, wren);
    end
  endtask

  task automatic test_single;
    int waited;
    load_row(5, {160{1'b1}});
    req0_row = 5; req0_col = 0; req0_tile = 4'hA; req = 2'b01;
    op(1'b0, waited);
    total++;
    if (waited !== 1) begin bad++; $display("FAIL single_latency: got %0d want 1", waited); end
    total++;
    if (ram[5] !== {4'hA, {156{1'b1}}}) begin bad++; $display("FAIL single_row: got %h want %h", ram[5], {4'hA, {156{1'b1}}}); end
  endtask

  task automatic test_tie;
    int waited;
    do_reset();
    req0_row = 5'($urandom_range(0, 29)); req0_col = 39; req0_tile = 4'h3;
    req1_row = 5'($urandom_range(0, 29)); req1_col = 20; req1_tile = 4'h7;
    req = 2'b11;
    op(1'b0, waited);
    op(1'b0, waited);
    total++;
    if (waited !== 2) begin bad++; $display("FAIL tie_gap: got %0d want 2", waited); end
    @(negedge CLOCK_50);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int waited;
    new_ops(1);
    req = 2'b10;
    op(1'b1, waited);
    op(1'b1, waited);
    total++;
    if (waited !== 2) begin bad++; $display("FAIL b2b_gap2: got %0d want 2", waited); end
    op(1'b0, waited);
    total++;
    if (waited !== 2) begin bad++; $display("FAIL b2b_gap3: got %0d want 2", waited); end
  endtask

  task automatic test_oob;
    int waited;
    req0_row = 3; req0_col = 45; req0_tile = 4'($urandom);
    req = 2'b01;
    op(1'b0, waited);
    req1_row = 31; req1_col = 7; req1_tile = 4'($urandom);
    req = 2'b10;
    op(1'b0, waited);
  endtask

  task automatic test_random;
    int waited;
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 2; j++)
        if (!req[j] && $urandom_range(0, 1) == 1) begin new_ops(j); req[j] = 1'b1; end
      if (req == 2'b00) begin new_ops(0); req[0] = 1'b1; end
      op(1'($urandom_range(0, 1)), waited);
    end
    req = 2'b00;
    repeat (RD_LAT + 4) @(negedge CLOCK_50);
  endtask

  task automatic test_reset_mid;
    int waited, n;
    req0_row = 7; req0_col = 10; req0_tile = 4'h5; req = 2'b01;
    n = 0;
    while (gnt === 2'b00 && n < 20) begin @(negedge CLOCK_50); n++; end
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    total++;
    if ({wren, busy, gnt, done} !== 6'd0) begin
      bad++;
      $display("FAIL reset_mid: got wren=%b busy=%b gnt=%b done=%b want 0", wren, busy, gnt, done);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    last  = 1;
    op(1'b0, waited);
    total++;
    if (waited !== 1) begin bad++; $display("FAIL reaccept_latency: got %0d want 1", waited); end
  endtask

  task automatic test_rdlat4;
    int n, kw, kd;
    logic [159:0] wd;
    logic [3:0] od;
    do_reset();
    req0_row = 5; req0_col = 0; req0_tile = 4'hA; req = 2'b01;
    n = 0;
    while (gnt4 === 2'b00 && n < 20) begin @(negedge CLOCK_50); n++; end
    req = 2'b00;
    kw = -1; kd = -1; wd = '0; od = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLOCK_50);
      if (wren4 === 1'b1 && kw < 0) begin kw = k; wd = wrdata4; end
      if (done4 === 2'b01 && kd < 0) begin kd = k; od = old_tile4; end
    end
    total++;
    if (kw !== 4 || kd !== 5) begin bad++; $display("FAIL rdlat4_timing: got wren@%0d done@%0d want 4 5", kw, kd); end
    total++;
    if (wd !== {4'hA, {156{1'b1}}} || od !== 4'hF) begin
      bad++;
      $display("FAIL rdlat4_data: got %h old=%h want %h old=f", wd, od, {4'hA, {156{1'b1}}});
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_single();
    test_tie();
    test_back_to_back();
    test_oob();
    test_random();
    test_reset_mid();
    test_rdlat4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
